// File: rtl/nr_alu_pkg.sv
// Shared definitions for the sequencer that drives the combinational nR_ALU:
// op-code constants and the sequencer FSM state encoding.
package nr_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_SL  = 4'd7;
    localparam logic [3:0] OP_SR  = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam logic [2:0] MUL_LAST_ITER = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_MUL   = 2'd2,
        ST_RESP  = 2'd3
    } nr_state_e;

    // Ops above MUL have no ALU meaning and are answered with an error response.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op > OP_MUL);
    endfunction

endpackage

// File: rtl/nr_alu_seq.sv
// Request/response sequencer around an external combinational ALU: single-cycle
// ops are issued once, MUL is built from eight shift-and-add ALU passes.
module nr_alu_seq
    import nr_alu_pkg::*;
#(
    parameter int OPW = 4,
    parameter int DW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [OPW-1:0] req_op,
    input  logic [DW-1:0]  req_a,
    input  logic [DW-1:0]  req_b,
    output logic [DW-1:0]  alu_in0,
    output logic [DW-1:0]  alu_in1,
    output logic [3:0]     alu_alo,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_zero,
    input  logic [1:0]     alu_ovf,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_zero,
    output logic [1:0]     rsp_ovf,
    output logic           rsp_err
);

    nr_state_e      state_q,    state_d;
    logic [OPW-1:0] op_q,       op_d;
    logic [DW-1:0]  a_q,        a_d;
    logic [DW-1:0]  b_q,        b_d;
    logic [DW-1:0]  acc_q,      acc_d;
    logic [DW-1:0]  mcand_q,    mcand_d;
    logic [DW-1:0]  mplier_q,   mplier_d;
    logic [2:0]     cnt_q,      cnt_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic           rsp_zero_q, rsp_zero_d;
    logic [1:0]     rsp_ovf_q,  rsp_ovf_d;
    logic           rsp_err_q,  rsp_err_d;

    logic [DW-1:0]  acc_next_s;
    logic [3:0]     op_low_s;
    logic           req_is_mul_s;
    logic           req_illegal_s;
    logic [3:0]     alu_alo_s;
    logic [DW-1:0]  alu_in0_s;
    logic [DW-1:0]  alu_in1_s;

    // Op-code classification of the incoming request; upper op bits beyond
    // the four defined ones make any wider op-code illegal.
    always_comb begin
        op_low_s      = req_op[3:0];
        req_is_mul_s  = 1'b0;
        req_illegal_s = 1'b0;
        if (OPW > 4) begin
            req_illegal_s = (req_op > OPW'(OP_MUL));
            req_is_mul_s  = (req_op == OPW'(OP_MUL));
        end else begin
            req_illegal_s = op_is_illegal(op_low_s);
            req_is_mul_s  = (op_low_s == OP_MUL);
        end
    end

    // Next-state, datapath register updates and ALU drive.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_err_d  = rsp_err_q;
        alu_alo_s  = 4'd0;
        alu_in0_s  = {DW{1'b0}};
        alu_in1_s  = {DW{1'b0}};
        acc_next_s = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (req_is_mul_s) begin
                        state_d   = ST_MUL;
                        acc_d     = {DW{1'b0}};
                        mcand_d   = req_a;
                        mplier_d  = req_b;
                        cnt_d     = 3'd0;
                        rsp_ovf_d = 2'b00;
                    end else if (req_illegal_s) begin
                        state_d    = ST_RESP;
                        rsp_data_d = {DW{1'b0}};
                        rsp_zero_d = 1'b0;
                        rsp_ovf_d  = 2'b00;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                alu_alo_s  = op_q[3:0];
                alu_in0_s  = a_q;
                alu_in1_s  = b_q;
                rsp_data_d = alu_out;
                rsp_zero_d = alu_zero;
                rsp_ovf_d  = alu_ovf;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end

            ST_MUL: begin
                // The ALU always sees acc+mcand; the sum is only kept when
                // the current multiplier bit is set.
                alu_alo_s = OP_ADD;
                alu_in0_s = acc_q;
                alu_in1_s = mcand_q;
                if (mplier_q[0]) begin
                    acc_next_s = alu_out;
                    rsp_ovf_d  = rsp_ovf_q | alu_ovf;
                end else begin
                    acc_next_s = acc_q;
                end
                acc_d    = acc_next_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == MUL_LAST_ITER) begin
                    state_d    = ST_RESP;
                    rsp_data_d = acc_next_s;
                    rsp_zero_d = (acc_next_s == {DW{1'b0}});
                    rsp_err_d  = 1'b0;
                end else begin
                    state_d = ST_MUL;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= {OPW{1'b0}};
            a_q        <= {DW{1'b0}};
            b_q        <= {DW{1'b0}};
            acc_q      <= {DW{1'b0}};
            mcand_q    <= {DW{1'b0}};
            mplier_q   <= {DW{1'b0}};
            cnt_q      <= 3'd0;
            rsp_data_q <= {DW{1'b0}};
            rsp_zero_q <= 1'b0;
            rsp_ovf_q  <= 2'b00;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_err   = rsp_err_q;
    assign alu_alo   = alu_alo_s;
    assign alu_in0   = alu_in0_s;
    assign alu_in1   = alu_in1_s;

endmodule

// File: tb/tb_nr_alu_seq.sv
// Directed bench for nr_alu_seq with a local behavioural stand-in for nR_ALU
// (ovf code = {carry/borrow, signed overflow} for ADD/SUB, 00 otherwise).
module tb_nr_alu_seq;

    localparam int DW  = 8;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic [DW-1:0]  req_a;
    logic [DW-1:0]  req_b;
    logic [DW-1:0]  alu_in0;
    logic [DW-1:0]  alu_in1;
    logic [3:0]     alu_alo;
    logic [DW-1:0]  alu_out;
    logic           alu_zero;
    logic [1:0]     alu_ovf;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [DW-1:0]  rsp_data;
    logic           rsp_zero;
    logic [1:0]     rsp_ovf;
    logic           rsp_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    nr_alu_seq #(.OPW(OPW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .alu_in0  (alu_in0),
        .alu_in1  (alu_in1),
        .alu_alo  (alu_alo),
        .alu_out  (alu_out),
        .alu_zero (alu_zero),
        .alu_ovf  (alu_ovf),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_zero (rsp_zero),
        .rsp_ovf  (rsp_ovf),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU sitting beside the sequencer.
    logic [DW:0] wide;
    always_comb begin
        wide    = {(DW+1){1'b0}};
        alu_out = {DW{1'b0}};
        alu_ovf = 2'b00;
        case (alu_alo)
            4'd0: begin
                wide    = {1'b0, alu_in0} + {1'b0, alu_in1};
                alu_out = wide[DW-1:0];
                alu_ovf = {wide[DW], (alu_in0[DW-1] == alu_in1[DW-1]) && (alu_out[DW-1] != alu_in0[DW-1])};
            end
            4'd1: begin
                wide    = {1'b0, alu_in0} - {1'b0, alu_in1};
                alu_out = wide[DW-1:0];
                alu_ovf = {wide[DW], (alu_in0[DW-1] != alu_in1[DW-1]) && (alu_out[DW-1] != alu_in0[DW-1])};
            end
            4'd2: alu_out = alu_in0 & alu_in1;
            4'd3: alu_out = alu_in0 | alu_in1;
            4'd4: alu_out = alu_in0 ^ alu_in1;
            4'd5: alu_out = ~(alu_in0 | alu_in1);
            4'd6: alu_out = ($signed(alu_in0) < $signed(alu_in1)) ? 8'd1 : 8'd0;
            4'd7: alu_out = alu_in0 << alu_in1[2:0];
            4'd8: alu_out = alu_in0 >> alu_in1[2:0];
            default: alu_out = {DW{1'b0}};
        endcase
    end
    assign alu_zero = (alu_out == {DW{1'b0}});

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       z;
        logic [1:0] ovf;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, wait for its response, check it, then release it.
    task automatic do_txn(input vec_t v, input string tag);
        int lat;
        int wait_cnt;
        @(negedge clk);
        wait_cnt = 0;
        while (!req_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk({tag, "_ready"}, int'(req_ready), 1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"},  lat, v.lat);
        chk({tag, "_data"}, int'(rsp_data), int'(v.d));
        chk({tag, "_zero"}, int'(rsp_zero), int'(v.z));
        chk({tag, "_ovf"},  int'(rsp_ovf),  int'(v.ovf));
        chk({tag, "_err"},  int'(rsp_err),  int'(v.err));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, int'({req_ready, rsp_valid}), 2);
    endtask

    initial begin
        int   saw_valid;
        vec_t v;

        //          op     a      b      data   z     ovf    err   lat
        vecs[0]  = '{4'd0, 8'd3,   8'd4,   8'd7,   1'b0, 2'b00, 1'b0, 2};
        vecs[1]  = '{4'd1, 8'd9,   8'd4,   8'd5,   1'b0, 2'b00, 1'b0, 2};
        vecs[2]  = '{4'd0, 8'd200, 8'd100, 8'd44,  1'b0, 2'b10, 1'b0, 2};
        vecs[3]  = '{4'd0, 8'd100, 8'd100, 8'd200, 1'b0, 2'b01, 1'b0, 2};
        vecs[4]  = '{4'd1, 8'd4,   8'd4,   8'd0,   1'b1, 2'b00, 1'b0, 2};
        vecs[5]  = '{4'd1, 8'd3,   8'd5,   8'hFE,  1'b0, 2'b10, 1'b0, 2};
        vecs[6]  = '{4'd2, 8'hF0,  8'h0F,  8'h00,  1'b1, 2'b00, 1'b0, 2};
        vecs[7]  = '{4'd3, 8'hF0,  8'h0F,  8'hFF,  1'b0, 2'b00, 1'b0, 2};
        vecs[8]  = '{4'd4, 8'hAA,  8'hFF,  8'h55,  1'b0, 2'b00, 1'b0, 2};
        vecs[9]  = '{4'd5, 8'h0F,  8'hF0,  8'h00,  1'b1, 2'b00, 1'b0, 2};
        vecs[10] = '{4'd6, 8'h80,  8'h01,  8'h01,  1'b0, 2'b00, 1'b0, 2};
        vecs[11] = '{4'd7, 8'h81,  8'h01,  8'h02,  1'b0, 2'b00, 1'b0, 2};
        vecs[12] = '{4'd8, 8'h80,  8'h03,  8'h10,  1'b0, 2'b00, 1'b0, 2};
        vecs[13] = '{4'd9, 8'd5,   8'd3,   8'd15,  1'b0, 2'b00, 1'b0, 9};
        vecs[14] = '{4'd9, 8'd16,  8'd16,  8'd0,   1'b1, 2'b00, 1'b0, 9};
        vecs[15] = '{4'd9, 8'hFF,  8'hFF,  8'h01,  1'b0, 2'b11, 1'b0, 9};
        vecs[16] = '{4'hC, 8'd7,   8'd7,   8'd0,   1'b0, 2'b00, 1'b1, 1};
        vecs[17] = '{4'hF, 8'hFF,  8'h01,  8'd0,   1'b0, 2'b00, 1'b1, 1};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 8'd0;
        req_b     = 8'd0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_flags", int'({rsp_data, rsp_zero, rsp_ovf, rsp_err}), 0);
        chk("rst_alu_drive", int'({alu_alo, alu_in0, alu_in1}), 0);

        for (int i = 0; i < 18; i++) begin
            do_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: SUB 9-4 held for three cycles with rsp_ready low.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd1;
        req_a     = 8'd9;
        req_b     = 8'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_issue_alu", int'({alu_alo, alu_in0, alu_in1}), int'({4'd1, 8'd9, 8'd4}));
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_n2", int'(rsp_valid), 1);
        chk("bp_resp_alu", int'({alu_alo, alu_in0, alu_in1}), 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold%0d", k), int'({rsp_valid, req_ready, rsp_data}), int'({1'b1, 1'b0, 8'd5}));
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("bp_release_cycle", int'({rsp_valid, req_ready, rsp_data}), int'({1'b1, 1'b0, 8'd5}));
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_idle_after", int'({req_ready, rsp_valid}), 2);

        // Reset asserted during MUL iteration 4 aborts with no response.
        req_valid = 1'b1;
        req_op    = 4'd9;
        req_a     = 8'd5;
        req_b     = 8'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mulrst_mul_alu", int'(alu_alo), 0);
        chk("mulrst_busy", int'(req_ready), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mulrst_idle", int'({req_ready, rsp_valid}), 2);
        chk("mulrst_cleared", int'({rsp_data, rsp_ovf, alu_in0, alu_in1}), 0);
        saw_valid = 0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1;
        end
        rsp_ready = 1'b0;
        chk("mulrst_no_rsp", saw_valid, 0);
        v = '{4'd0, 8'd1, 8'd1, 8'd2, 1'b0, 2'b00, 1'b0, 2};
        do_txn(v, "post_rst_add");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/nr_alu_seq.md
NR_ALU_SEQ -- requirements
Module: nr_alu_seq

Interface
REQ-001 SHALL have parameter OPW, default 4, ALU op-code width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have port clk, input, 1, the single clock (all logic on rising edge).
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when both valid and ready are high.
REQ-007 SHALL have port req_op, input, OPW, operation code.
REQ-008 SHALL have port req_a, input, DW, operand A.
REQ-009 SHALL have port req_b, input, DW, operand B.
REQ-010 SHALL have port alu_in0, output, DW, drives the combinational ALU in0.
REQ-011 SHALL have port alu_in1, output, DW, drives the combinational ALU in1.
REQ-012 SHALL have port alu_alo, output, 4, ALU control bits.
REQ-013 SHALL have port alu_out, input, DW, ALU result.
REQ-014 SHALL have port alu_zero, input, 1, ALU zero/condition flag.
REQ-015 SHALL have port alu_ovf, input, 2, ALU overflow code.
REQ-016 SHALL have port rsp_valid, output, 1, result present.
REQ-017 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-018 SHALL have port rsp_data, output, DW, result.
REQ-019 SHALL have port rsp_zero, output, 1, captured zero flag.
REQ-020 SHALL have port rsp_ovf, output, 2, captured overflow code.
REQ-021 SHALL have port rsp_err, output, 1, illegal op.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, MUL, RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; on accept, op/A/B are registered.
REQ-024 Accept of op 0-8 SHALL transition IDLE->ISSUE: alu_alo=op, alu_in0=A, alu_in1=B. At the end of ISSUE, alu_out/zero/ovf are captured into rsp regs. Next state is RESP.
REQ-025 Single-cycle op latency SHALL be exactly 2: rsp_valid asserts in cycle N+2 for an accept in cycle N.
REQ-026 Op 9 (MUL) SHALL transition IDLE->MUL and run exactly 8 iterations with an internal 3-bit counter (0..7).
REQ-027 Each MUL iteration SHALL proceed as follows: if multiplier LSB = 1, then acc <= alu_out with alu_alo=0 (add), alu_in0=acc, alu_in1=mcand. Then mcand <<= 1 and mplier >>= 1 internally. rsp_ovf is the sticky OR of alu_ovf over the adds that were taken.
REQ-028 The MUL result SHALL be the low DW bits of the product. rsp_zero = (result==0). rsp_valid asserts in cycle N+9.
REQ-029 Ops 10-15 SHALL go IDLE->RESP directly with rsp_data=0, rsp_zero=0, rsp_ovf=0, rsp_err=1. rsp_valid asserts in cycle N+1.
REQ-030 In RESP, rsp_valid=1 and all rsp_* outputs SHALL remain stable until rsp_ready=1, then the FSM returns to IDLE. No request is accepted in that same cycle.
REQ-031 Outside ISSUE/MUL, alu_alo/alu_in0/alu_in1 SHALL be driven to 0.
REQ-032 ALU results SHALL be passed through unmodified; no re-interpretation of the overflow code.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_ovf=0, rsp_err=0, alu_* =0, counter/acc cleared.
REQ-034 Reset mid-operation (ISSUE, MUL or RESP) SHALL abort it with no response. A pending rsp SHALL be dropped.

Structure
REQ-035 Shared package nr_alu_pkg SHALL hold the op-code constants (ADD=0..SR=8, MUL=9) and the FSM state enum.
REQ-036 No sub-module is required. The combinational nR_ALU SHALL be instantiated beside this block at the next level up.

Verification
REQ-037 ADD: A=3, B=4, op 0 -> rsp_data=7, zero=0, ovf=00, rsp_valid at N+2.
REQ-038 MUL: A=5, B=3, op 9 -> rsp_data=15, ovf=00, zero=0, rsp_valid at N+9.
REQ-039 Backpressure: SUB 9-4 with rsp_ready low for 3 cycles -> rsp_data=5 held stable, req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
REQ-040 Illegal op 4'hC -> rsp_err=1, rsp_data=0, rsp_valid at N+1.
REQ-041 rst pulsed during MUL iteration 4 -> next cycle state IDLE, rsp_valid=0, req_ready=1; a following ADD 1+1 returns 2.
